if_id_reg: RTL and testbench

- Pipeline register between the Instruction Fetch and Instruction Decode stages of the 5-stage MIPS-style CPU.
- Captures the fetched instruction and its PC+4 every clock cycle.
- Supports a stall (hold) controlled by the write enable, and a flush (bubble insertion) controlled by the branch-taken signal `zero`.
- Sits between the PC/instruction-memory (cache) path and the decode/register-file stage.

---
 rtl/if_id_reg.sv | 52 +++++
 tb/tb_if_id_reg.sv | 115 +++++++++++
 2 files changed

// File: rtl/if_id_reg.sv
// IF/ID pipeline register for the 5-stage MIPS-style core.
// Latches the fetched instruction and its PC+4 for the decode stage.
// A low rst or a taken-branch flush (zero) turns the stage into a bubble:
// PC+4 cleared, instruction replaced by NOP_INSN. Reset wins over flush,
// flush wins over stall, and otherwise we selects load versus hold.
// Both fields always move together, and the outputs come straight from flops.
module if_id_reg #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_INSN = 32'h00000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_4,
    input  logic [DATA_W-1:0] ins,
    input  logic              we,
    input  logic              zero,
    output logic [DATA_W-1:0] pc_4_out,
    output logic [DATA_W-1:0] ins_out
);

    logic              bubble;
    logic [DATA_W-1:0] pc_4_nxt;
    logic [DATA_W-1:0] ins_nxt;

    // Pick the next stage contents. A flush ignores we, so a stalled
    // instruction on the wrong path is discarded rather than held.
    always_comb begin
        pc_4_nxt = pc_4_out;
        ins_nxt  = ins_out;
        bubble   = zero;
        if (bubble) begin
            pc_4_nxt = '0;
            ins_nxt  = NOP_INSN;
        end else if (we) begin
            pc_4_nxt = pc_4;
            ins_nxt  = ins;
        end
    end

    // Register the stage. The reset is sampled on the clock edge, so a pulse
    // on rst that does not span an edge leaves the contents unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_4_out <= '0;
            ins_out  <= NOP_INSN;
        end else begin
            pc_4_out <= pc_4_nxt;
            ins_out  <= ins_nxt;
        end
    end

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios followed by random
// traffic, compared against a rule-based model of the stage contents.
module tb_if_id_reg;

    localparam logic [31:0] NOP = 32'h00000000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_4;
    logic [31:0] ins;
    logic        we;
    logic        zero;
    logic [31:0] pc_4_out;
    logic [31:0] ins_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_ins;

    if_id_reg #(.DATA_W(32), .NOP_INSN(NOP)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc_4     (pc_4),
        .ins      (ins),
        .we       (we),
        .zero     (zero),
        .pc_4_out (pc_4_out),
        .ins_out  (ins_out)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model from
    // the stage rules, then compare just after the edge.
    task automatic cycle(input string tag, input logic r, input logic w, input logic z,
                         input logic [31:0] p, input logic [31:0] i);
        rst  = r;
        we   = w;
        zero = z;
        pc_4 = p;
        ins  = i;
        @(posedge clk);
        if (!r || z) begin
            exp_pc  = 32'h0;
            exp_ins = NOP;
        end else if (w) begin
            exp_pc  = p;
            exp_ins = i;
        end
        #1;
        check({tag, ".pc"},  pc_4_out, exp_pc);
        check({tag, ".ins"}, ins_out,  exp_ins);
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; zero = 1'b0; pc_4 = '0; ins = '0;
        exp_pc = 'x; exp_ins = 'x;

        cycle("reset0", 0, 1, 0, 32'h40, 32'h8C010004);
        cycle("reset1", 0, 1, 0, 32'h40, 32'h8C010004);

        cycle("load0", 1, 1, 0, 32'd4, 32'h00000824);
        cycle("load1", 1, 1, 0, 32'd8, 32'h20020005);

        for (int k = 0; k < 3; k++)
            cycle("stall", 1, 0, 0, 32'd12, 32'hAC020000);
        cycle("unstall", 1, 1, 0, 32'd12, 32'hAC020000);

        cycle("flush", 1, 1, 1, 32'd16, 32'h10220003);
        cycle("after_flush", 1, 1, 0, 32'd16, 32'h10220003);

        cycle("flush_stall", 1, 0, 1, 32'd20, 32'h12345678);
        cycle("reload", 1, 1, 0, 32'd24, 32'hDEADBEEF);
        cycle("flush_rst", 0, 1, 1, 32'd28, 32'h11111111);
        cycle("reload2", 1, 1, 0, 32'd32, 32'h22222222);
        cycle("rst_stall", 0, 0, 0, 32'd36, 32'h33333333);
        cycle("reload3", 1, 1, 0, 32'd40, 32'h44444444);

        // rst pulse wholly between edges must not disturb the stage.
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("glitch.pc",  pc_4_out, exp_pc);
        check("glitch.ins", ins_out,  exp_ins);
        cycle("glitch_hold", 1, 0, 0, 32'd44, 32'h55555555);

        cycle("boundary", 1, 1, 0, 32'hFFFFFFFC, 32'hFFFFFFFF);

        for (int k = 0; k < 300; k++) begin
            logic r, w, z;
            r = ($urandom_range(0, 19) != 0);
            w = ($urandom_range(0, 9) < 7);
            z = ($urandom_range(0, 99) < 15);
            cycle("rand", r, w, z, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
